// File: rtl/apbDecode_package.sv
// Shared arbitration types and default sizing for memory-port arbiters.
// Used by mem_port_arbiter and its round-robin picker.
package apbDecode_package;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arbState_t;

    localparam int MEM_ARB_NUM_REQ  = 4;
    localparam int MEM_ARB_LOCK_TMO = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above the pointer,
// wrapping at N. Returns a one-hot grant, its index and an any-grant flag.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] p,
                                               input int k);
        int s;
        s = int'(p) + k;
        if (s >= N) s = s - N;
        return IW'(s);
    endfunction

    logic [IW-1:0] w_j;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_j     = '0;
        for (int k = 0; k < N; k++) begin
            w_j = wrap_add(i_ptr, k);
            if (!o_any && i_req[w_j]) begin
                o_any        = 1'b1;
                o_idx        = w_j;
                o_grant[w_j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port, with per-request locking,
// lock timeout, a registered command and read-data routing back to the issuer.
module mem_port_arbiter
    import apbDecode_package::*;
#(
    parameter int NUM_REQ  = MEM_ARB_NUM_REQ,
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 37,
    parameter int RD_LAT   = 1,
    parameter int LOCK_TMO = MEM_ARB_LOCK_TMO
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ-1:0]        req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      mem_en,
    output logic                      mem_write,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic                      lock_err
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = $clog2(LOCK_TMO + 1);

    arbState_t     r_state, w_state_nxt;
    logic [IW-1:0] r_ptr, w_ptr_nxt;
    logic [IW-1:0] r_owner, w_owner_nxt;
    logic [TW-1:0] r_tmo, w_tmo_nxt;
    logic          r_lock_err, w_lock_to;

    logic [NUM_REQ-1:0] w_mask, w_grant;
    logic [IW-1:0]      w_idx;
    logic               w_xfer;

    logic [ADDR_W-1:0] w_addr_arr [NUM_REQ];
    logic [DATA_W-1:0] w_data_arr [NUM_REQ];

    logic              r_mem_en, r_mem_write;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    logic [RD_LAT:0] r_pv;
    logic [IW-1:0]   r_pid [RD_LAT+1];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
        assign w_data_arr[g] = req_wdata[g*DATA_W +: DATA_W];
    end

    function automatic logic [IW-1:0] inc_wrap(input logic [IW-1:0] x);
        return (x == IW'(NUM_REQ - 1)) ? '0 : x + 1'b1;
    endfunction

    // While locked, only the owner's request is visible to the picker.
    always_comb begin
        w_mask = req_valid;
        if (r_state == ARB_LOCKED)
            w_mask = req_valid & (NUM_REQ'(1) << r_owner);
    end

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .i_req   (w_mask),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_xfer)
    );

    assign req_ready = w_grant;

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        w_tmo_nxt   = r_tmo;
        w_lock_to   = 1'b0;
        unique case (r_state)
            ARB_IDLE: begin
                if (w_xfer) begin
                    w_ptr_nxt = inc_wrap(w_idx);
                    if (req_lock[w_idx]) begin
                        w_state_nxt = ARB_LOCKED;
                        w_owner_nxt = w_idx;
                        w_tmo_nxt   = '0;
                    end
                end
            end
            ARB_LOCKED: begin
                if (w_xfer) begin
                    w_tmo_nxt = '0;
                    if (!req_lock[r_owner]) begin
                        w_state_nxt = ARB_IDLE;
                        w_ptr_nxt   = inc_wrap(r_owner);
                    end
                end else if (r_tmo >= TW'(LOCK_TMO - 1)) begin
                    w_state_nxt = ARB_IDLE;
                    w_ptr_nxt   = inc_wrap(r_owner);
                    w_tmo_nxt   = TW'(LOCK_TMO);
                    w_lock_to   = 1'b1;
                end else begin
                    w_tmo_nxt = r_tmo + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ARB_IDLE;
            r_ptr      <= '0;
            r_owner    <= '0;
            r_tmo      <= '0;
            r_lock_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_owner    <= w_owner_nxt;
            r_tmo      <= w_tmo_nxt;
            r_lock_err <= w_lock_to;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_en    <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_en    <= w_xfer;
            r_mem_write <= w_xfer & req_write[w_idx];
            if (w_xfer) begin
                r_mem_addr  <= w_addr_arr[w_idx];
                r_mem_wdata <= w_data_arr[w_idx];
            end
        end
    end

    // Requester id follows each read through the command and memory stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pv <= '0;
            for (int k = 0; k <= RD_LAT; k++)
                r_pid[k] <= '0;
        end else begin
            r_pv     <= {r_pv[RD_LAT-1:0], w_xfer & ~req_write[w_idx]};
            r_pid[0] <= w_idx;
            for (int k = 1; k <= RD_LAT; k++)
                r_pid[k] <= r_pid[k-1];
        end
    end

    assign rsp_valid = r_pv[RD_LAT] ? (NUM_REQ'(1) << r_pid[RD_LAT]) : '0;
    assign rsp_rdata = mem_rdata;
    assign mem_en    = r_mem_en;
    assign mem_write = r_mem_write;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign lock_err  = r_lock_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 1-cycle behavioural memory
// and a short random phase checked against a shadow memory.
module tb_mem_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 37;

    logic            clk, rst;
    logic [N-1:0]    req_valid, req_write, req_lock;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    req_ready, rsp_valid;
    logic [DW-1:0]   rsp_rdata, mem_wdata, mem_rdata;
    logic            mem_en, mem_write, lock_err;
    logic [AW-1:0]   mem_addr;

    int n_chk  = 0;
    int n_pass = 0;

    mem_port_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_lock  (req_lock),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_en    (mem_en),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .lock_err  (lock_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] memval(input logic [AW-1:0] a);
        return 37'h0A00000000 | {29'h0, a};
    endfunction

    logic [DW-1:0] mem   [256];
    logic          wflag [256];
    logic          mem_clr;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) wflag[i] <= 1'b0;
        end else if (mem_en) begin
            if (mem_write) begin
                mem[mem_addr]   <= mem_wdata;
                wflag[mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= wflag[mem_addr] ? mem[mem_addr] : memval(mem_addr);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic set_req(input int i, input logic w, input logic lk,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_write[2'(i)]       = w;
        req_lock[2'(i)]        = lk;
        req_addr[i*AW +: AW]   = a;
        req_wdata[i*DW +: DW]  = d;
    endtask

    logic [DW-1:0] sh  [256];
    logic          q0v, q1v, ev;
    logic [1:0]    q0id, q1id, eid;
    logic [DW-1:0] q0d, q1d, ed;
    logic [AW-1:0] ta;

    initial begin
        rst = 1'b1; mem_clr = 1'b1;
        req_valid = '0; req_write = '0; req_lock = '0;
        req_addr = '0; req_wdata = '0;
        repeat (2) @(posedge clk);
        #3;
        check("rst_ready", req_ready, 0);
        check("rst_rsp", rsp_valid, 0);
        check("rst_cmd", {mem_en, mem_write, mem_addr, mem_wdata}, 0);
        check("rst_lockerr", lock_err, 0);
        @(posedge clk); #1;
        rst = 1'b0; mem_clr = 1'b0;

        // Four simultaneous reads drain in round-robin order.
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, AW'(i), '0);
        for (int k = 0; k < 6; k++) begin
            logic [3:0] vv;
            tick();
            vv = 4'b1111;
            req_valid = 4'(vv << k);
            settle();
            check("rr_ready", req_ready, (k < 4) ? 4'(1 << k) : 4'd0);
            check("rr_memen", mem_en, (k >= 1 && k <= 4));
            if (k >= 1 && k <= 4) check("rr_addr", mem_addr, k - 1);
            check("rr_rspv", rsp_valid,
                  (k >= 2) ? 4'(1 << (k - 2)) : 4'd0);
            if (k >= 2) check("rr_rdata", rsp_rdata, memval(AW'(k - 2)));
        end

        // Write then read of the same address by a different requester.
        tick();
        set_req(0, 1'b1, 1'b0, 8'd5, 37'h1063686172);
        req_valid = 4'b0001;
        settle();
        check("raw_g0", req_ready, 4'b0001);
        tick();
        set_req(2, 1'b0, 1'b0, 8'd5, '0);
        req_valid = 4'b0100;
        settle();
        check("raw_g2", req_ready, 4'b0100);
        check("raw_wcmd", {mem_en, mem_write, mem_addr, mem_wdata},
              {2'b11, 8'd5, 37'h1063686172});
        tick();
        req_valid = '0;
        settle();
        check("raw_norsp", rsp_valid, 0);
        check("raw_rcmd", {mem_en, mem_write}, 2'b10);
        tick();
        settle();
        check("raw_rspv", rsp_valid, 4'b0100);
        check("raw_rdata", rsp_rdata, 37'h1063686172);

        // Locked read-modify-write by req1 while req0 and req3 compete.
        tick();
        set_req(1, 1'b0, 1'b1, 8'd9, '0);
        set_req(0, 1'b0, 1'b0, 8'd0, '0);
        set_req(3, 1'b0, 1'b0, 8'd3, '0);
        req_valid = 4'b0010;
        settle();
        check("lk_g1", req_ready, 4'b0010);
        tick();
        req_valid = 4'b1001;
        settle();
        check("lk_block", req_ready, 4'b0000);
        tick();
        set_req(1, 1'b1, 1'b0, 8'd9, 37'h0000BEEF);
        req_valid = 4'b1011;
        settle();
        check("lk_owner", req_ready, 4'b0010);
        check("lk_rspv", rsp_valid, 4'b0010);
        check("lk_rdata", rsp_rdata, memval(8'd9));
        tick();
        set_req(1, 1'b0, 1'b0, 8'd9, '0);
        req_valid = 4'b1001;
        settle();
        check("lk_next", req_ready, 4'b1000);
        tick();
        req_valid = '0;
        tick();
        tick();

        // Lock abandoned by req2 times out after LOCK_TMO idle cycles.
        tick();
        set_req(2, 1'b0, 1'b1, 8'd5, '0);
        req_valid = 4'b0100;
        settle();
        check("tmo_g2", req_ready, 4'b0100);
        for (int k = 1; k <= 16; k++) begin
            tick();
            req_lock = '0;
            req_valid = 4'b1000;
            settle();
            check("tmo_hold", {req_ready, lock_err}, 5'b0);
        end
        tick();
        settle();
        check("tmo_err", lock_err, 1'b1);
        check("tmo_g3", req_ready, 4'b1000);
        tick();
        req_valid = '0;
        settle();
        check("tmo_pulse", lock_err, 1'b0);
        tick();
        tick();

        // Reset with two reads in flight.
        tick();
        set_req(0, 1'b0, 1'b0, 8'd0, '0);
        set_req(1, 1'b0, 1'b0, 8'd9, '0);
        req_valid = 4'b0001;
        settle();
        check("ar_g0", req_ready, 4'b0001);
        tick();
        req_valid = 4'b0010;
        settle();
        check("ar_g1", req_ready, 4'b0010);
        #1;
        rst = 1'b1;
        req_valid = '0;
        #1;
        check("ar_async", {mem_en, rsp_valid}, 5'b0);
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            settle();
            check("ar_quiet", {mem_en, rsp_valid}, 5'b0);
        end
        tick();
        req_valid = 4'b1111;
        settle();
        check("ar_ptr0", req_ready, 4'b0001);
        check("ar_noen", mem_en, 1'b0);
        tick();
        req_valid = '0;
        settle();
        check("ar_en", mem_en, 1'b1);
        repeat (3) tick();

        // Random traffic against a shadow memory.
        for (int i = 0; i < 256; i++)
            sh[i] = wflag[i] ? mem[i] : memval(AW'(i));
        q0v = 1'b0; q1v = 1'b0;
        q0id = '0; q1id = '0; q0d = '0; q1d = '0;
        for (int c = 0; c < 400; c++) begin
            tick();
            req_valid = 4'($urandom_range(0, 15));
            for (int i = 0; i < N; i++)
                set_req(i, 1'($urandom_range(0, 1)),
                        ($urandom_range(0, 3) == 0),
                        AW'($urandom_range(0, 15)),
                        {5'($urandom), 32'($urandom)});
            settle();
            check("st_grant",
                  $onehot0(req_ready) && ((req_ready & ~req_valid) == 0), 1);
            check("st_rspv", rsp_valid, q1v ? 4'(1 << q1id) : 4'd0);
            if (q1v) check("st_rdata", rsp_rdata, q1d);
            ev = 1'b0; eid = '0; ed = '0;
            for (int i = 0; i < N; i++) begin
                if (req_ready[2'(i)] && req_valid[2'(i)]) begin
                    ta = req_addr[i*AW +: AW];
                    if (req_write[2'(i)]) begin
                        sh[ta] = req_wdata[i*DW +: DW];
                    end else begin
                        ev = 1'b1; eid = 2'(i); ed = sh[ta];
                    end
                end
            end
            q1v = q0v; q1id = q0id; q1d = q0d;
            q0v = ev;  q0id = eid;  q0d = ed;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
